// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register, condition evaluation and registered write-strobe gating; optional COND_STATS_EN adds squash_count.
module cond_unit #(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [3:0]  Cond,
  input  logic [3:0]  ALUFlags,
  input  logic [1:0]  FlagW,
  input  logic        PCS,
  input  logic        RegW,
  input  logic        MemW,
  input  logic        NoWrite,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        CondEx,
`ifdef COND_STATS_EN
  output logic [15:0] squash_count,
`endif
  output logic [3:0]  Flags
);
  logic [3:0] flags_q, flags_d;
  logic       pc_src_q, pc_src_d, reg_write_q, reg_write_d;
  logic       mem_write_q, mem_write_d, cond_ex_q, cond_ex_d;
  logic       n, z, c, v, base, cex, accept;
  assign {n, z, c, v} = flags_q;
  assign accept = en & ~flush;
  // Odd codes invert their even partner; base=1 for 111 makes 1110 pass and 1111 fail.
  always_comb begin
    base = 1'b1;
    case (Cond[3:1])
      3'b000: base = z;
      3'b001: base = c;
      3'b010: base = n;
      3'b011: base = v;
      3'b100: base = c & ~z;
      3'b101: base = n == v;
      3'b110: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    cex = base ^ Cond[0];
  end
  always_comb begin
    pc_src_d    = flush ? 1'b0 : accept ? PCS & cex : pc_src_q;
    reg_write_d = flush ? 1'b0 : accept ? RegW & cex & ~NoWrite : reg_write_q;
    mem_write_d = flush ? 1'b0 : accept ? MemW & cex : mem_write_q;
    cond_ex_d   = flush ? 1'b0 : accept ? cex : cond_ex_q;
    flags_d[3:2] = (accept & cex & FlagW[1]) ? ALUFlags[3:2] : flags_q[3:2];
    flags_d[1:0] = (accept & cex & FlagW[0]) ? ALUFlags[1:0] : flags_q[1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_src_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      cond_ex_q   <= 1'b0;
      flags_q     <= FLAG_RESET;
    end else begin
      pc_src_q    <= pc_src_d;
      reg_write_q <= reg_write_d;
      mem_write_q <= mem_write_d;
      cond_ex_q   <= cond_ex_d;
      flags_q     <= flags_d;
    end
  end
  assign PCSrc    = pc_src_q;
  assign RegWrite = reg_write_q;
  assign MemWrite = mem_write_q;
  assign CondEx   = cond_ex_q;
  assign Flags    = flags_q;
`ifdef COND_STATS_EN
  logic [15:0] squash_q, squash_d;
  always_comb squash_d = (accept & ~cex & (squash_q != 16'hFFFF)) ? squash_q + 16'd1 : squash_q;
  always_ff @(posedge clk) squash_q <= reset ? 16'd0 : squash_d;
  assign squash_count = squash_q;
`endif
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: table-driven check of cond_unit plus condition sweep, reset and optional squash counter sequences.
module tb_cond_unit;
  logic clk = 1'b0, reset, en, flush, PCS, RegW, MemW, NoWrite;
  logic [3:0] Cond, ALUFlags, Flags;
  logic [1:0] FlagW;
  logic PCSrc, RegWrite, MemWrite, CondEx;
  int tests = 0, fails = 0;
`ifdef COND_STATS_EN
  logic [15:0] squash_count;
`endif
  cond_unit #(.FLAG_RESET(4'b0000)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
`ifdef COND_STATS_EN
    .squash_count(squash_count),
`endif
    .Flags(Flags)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic en, flush;
    logic [3:0] cond, alu;
    logic [1:0] fw;
    logic pcs, regw, memw, nowr;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[18];
  function automatic vec_t mk(input logic e, input logic f, input logic [3:0] c, input logic [3:0] a,
                              input logic [1:0] w, input logic p, input logic r, input logic m,
                              input logic nw, input logic [7:0] x);
    vec_t t;
    t.en = e; t.flush = f; t.cond = c; t.alu = a; t.fw = w;
    t.pcs = p; t.regw = r; t.memw = m; t.nowr = nw; t.exp = x;
    return t;
  endfunction
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic nn, zz, cc, vv;
    {nn, zz, cc, vv} = f;
    case (c)
      4'h0: return zz;        4'h1: return !zz;
      4'h2: return cc;        4'h3: return !cc;
      4'h4: return nn;        4'h5: return !nn;
      4'h6: return vv;        4'h7: return !vv;
      4'h8: return cc && !zz; 4'h9: return !cc || zz;
      4'hA: return nn == vv;  4'hB: return nn != vv;
      4'hC: return !zz && (nn == vv);
      4'hD: return zz || (nn != vv);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  task automatic drive(input vec_t t);
    en = t.en; flush = t.flush; Cond = t.cond; ALUFlags = t.alu; FlagW = t.fw;
    PCS = t.pcs; RegW = t.regw; MemW = t.memw; NoWrite = t.nowr;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got {PCSrc,RegWrite,MemWrite,CondEx,Flags}=%b, expected %b", name, got, exp);
    end
  endtask
  function automatic logic [7:0] outs();
    return {PCSrc, RegWrite, MemWrite, CondEx, Flags};
  endfunction
  initial begin
    // exp = {PCSrc, RegWrite, MemWrite, CondEx, Flags}
    vecs[0]  = mk(1, 0, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 8'b0000_0000);
    vecs[1]  = mk(1, 0, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0, 8'b0101_0000);
    vecs[2]  = mk(1, 0, 4'b1110, 4'b0100, 2'b11, 0, 1, 0, 1, 8'b0001_0100);
    vecs[3]  = mk(1, 0, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0, 8'b1001_0100);
    vecs[4]  = mk(1, 0, 4'b1110, 4'b1010, 2'b11, 0, 0, 0, 0, 8'b0001_1010);
    vecs[5]  = mk(1, 0, 4'b1110, 4'b0101, 2'b10, 0, 0, 0, 0, 8'b0001_0110);
    vecs[6]  = mk(1, 0, 4'b1110, 4'b1001, 2'b01, 0, 0, 0, 0, 8'b0001_0101);
    vecs[7]  = mk(1, 0, 4'b0001, 4'b1111, 2'b11, 1, 1, 1, 0, 8'b0000_0101);
    vecs[8]  = mk(1, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 1, 0, 8'b0011_0101);
    vecs[9]  = mk(0, 0, 4'b1110, 4'b0000, 2'b11, 1, 1, 0, 0, 8'b0011_0101);
    vecs[10] = mk(0, 0, 4'b0001, 4'b1010, 2'b10, 0, 1, 0, 0, 8'b0011_0101);
    vecs[11] = mk(0, 0, 4'b1111, 4'b0011, 2'b01, 1, 0, 0, 1, 8'b0011_0101);
    vecs[12] = mk(1, 1, 4'b1110, 4'b1000, 2'b11, 0, 0, 1, 0, 8'b0000_0101);
    vecs[13] = mk(1, 0, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0, 8'b0101_0101);
    vecs[14] = mk(0, 1, 4'b1110, 4'b0000, 2'b11, 1, 1, 1, 0, 8'b0000_0101);
    vecs[15] = mk(1, 0, 4'b1111, 4'b0000, 2'b11, 1, 1, 1, 0, 8'b0000_0101);
    vecs[16] = mk(1, 0, 4'b1100, 4'b0000, 2'b00, 1, 0, 0, 0, 8'b0000_0101);
    vecs[17] = mk(1, 0, 4'b1101, 4'b0000, 2'b00, 1, 0, 0, 0, 8'b1001_0101);
    reset = 1'b1;
    drive(mk(1, 0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 8'h00));
    drive(mk(1, 0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 8'h00));
    check("reset_state", outs(), 8'h00);
    reset = 1'b0;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end
    // Sweep: load each flag value, then probe every condition with no flag write.
    for (int f = 0; f < 16; f++) begin
      drive(mk(1, 0, 4'b1110, 4'(f), 2'b11, 0, 0, 0, 0, 8'h00));
      for (int c = 0; c < 16; c++) begin
        drive(mk(1, 0, 4'(c), ~4'(f), (c == 15) ? 2'b11 : 2'b00, 0, 1, 0, 0, 8'h00));
        check($sformatf("sweep_c%0d_f%0d", c, f), outs(),
              {1'b0, cond_ok(4'(c), 4'(f)), 1'b0, cond_ok(4'(c), 4'(f)), 4'(f)});
      end
    end
    drive(mk(1, 0, 4'b1110, 4'b1011, 2'b11, 1, 1, 1, 0, 8'h00));
    check("preload_mid", outs(), 8'b1111_1011);
    reset = 1'b1;
    drive(mk(1, 0, 4'b1110, 4'b0110, 2'b11, 1, 1, 1, 0, 8'h00));
    check("reset_mid_stream", outs(), 8'h00);
    reset = 1'b0;
`ifdef COND_STATS_EN
    tests++;
    if (squash_count !== 16'd0) begin fails++; $display("FAIL squash_reset: got %0d expected 0", squash_count); end
    for (int i = 0; i < 5; i++) drive(mk(1, 0, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < 2; i++) drive(mk(1, 1, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0, 8'h00));
    drive(mk(0, 0, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0, 8'h00));
    tests++;
    if (squash_count !== 16'd5) begin fails++; $display("FAIL squash_five: got %0d expected 5", squash_count); end
    for (int i = 0; i < 65530; i++) drive(mk(1, 0, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0, 8'h00));
    tests++;
    if (squash_count !== 16'hFFFF) begin fails++; $display("FAIL squash_full: got %h expected ffff", squash_count); end
    drive(mk(1, 0, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0, 8'h00));
    tests++;
    if (squash_count !== 16'hFFFF) begin fails++; $display("FAIL squash_sat: got %h expected ffff", squash_count); end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution and status-flag unit for the ARM-style datapath. It holds the architectural NZCV flags register fed by the ALU's 4-bit `ALUFlags` output ({N,Z,C,V}). It evaluates each instruction's 4-bit condition field against the stored flags, gates the PC/register/memory write strobes, and registers them into the next pipeline stage. It sits between the decoder/ALU stage and the writeback/memory control.

## Interface
- `FLAG_RESET`, default 4'b0000: reset value of the flags register, {N,Z,C,V}.

Ports:
- `clk` input 1: the single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `en` input 1: stage advance. 0 means stall: hold all state.
- `flush` input 1: kill the instruction currently presented.
- `Cond` input 4: ARM condition field.
- `ALUFlags` input 4: {N,Z,C,V} produced by the ALU for this instruction.
- `FlagW` input 2: [1] writes N,Z; [0] writes C,V.
- `PCS` input 1: instruction writes PC.
- `RegW` input 1: instruction writes the register file.
- `MemW` input 1: instruction writes memory.
- `NoWrite` input 1: compare-type instruction; suppresses the register write.
- `PCSrc` output 1: registered, gated PC write.
- `RegWrite` output 1: registered, gated register write.
- `MemWrite` output 1: registered, gated memory write.
- `CondEx` output 1: registered condition-pass bit of the last accepted instruction.
- `Flags` output 4: current flags register, {N,Z,C,V}.
- `squash_count` output 16: only with `COND_STATS_EN`; count of failed-condition instructions.

## Operation
- Condition evaluation (`cex`) is combinational from `Cond` and the `Flags` register. It never uses `ALUFlags` of the same instruction.
- Condition codes:
  - 0000 EQ: Z. 0001 NE: !Z. 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N. 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C & !Z. 1001 LS: !C | Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z & (N==V). 1101 LE: Z | (N!=V).
  - 1110 AL: 1. 1111: reserved, evaluates to 0.
- An instruction is accepted on an edge where `en`=1 and `flush`=0. On an accepted edge:
  - `PCSrc` <= PCS & cex.
  - `RegWrite` <= RegW & cex & !NoWrite.
  - `MemWrite` <= MemW & cex.
  - `CondEx` <= cex.
  - Flags[3:2] <= ALUFlags[3:2] if FlagW[1] & cex.
  - Flags[1:0] <= ALUFlags[1:0] if FlagW[0] & cex.
  - Flag fields that are not written hold their value.
- Edge with `flush`=1, regardless of `en`:
  - `PCSrc`, `RegWrite`, `MemWrite`, `CondEx` <= 0.
  - Flags unchanged.
- Edge with `en`=0 and `flush`=0: all registers hold, including the flags and the four registered outputs.
- Priority: reset > flush > en.

## Timing
- Reset values: `PCSrc`=`RegWrite`=`MemWrite`=`CondEx`=0, `Flags`=`FLAG_RESET`, `squash_count`=0.
- Latency is one cycle. Inputs presented before edge k appear on the gated outputs after edge k.
- Flag update is visible on `Flags` after the same edge. The next accepted instruction evaluates against it, so back-to-back CMP then BEQ works with no bubble.
- Stall: while `en`=0, the outputs stay at the last accepted instruction's values. Upstream must hold the inputs stable.
- Reset asserted mid-stream overrides any pending accept or flush on that edge.
- `FlagW` with cex=0 performs no write, including partial writes.
- `Cond`=1111 never executes and never writes flags.

## Configuration
- `COND_STATS_EN` defined:
  - `squash_count` port and counter exist.
  - The counter increments on each accepted instruction with cex=0.
  - It saturates at 16'hFFFF and clears on reset.
  - Flushed and stalled cycles do not count.
- `COND_STATS_EN` undefined: no port, no counter. All other behaviour is identical.

## Test plan
- Reset with `FLAG_RESET`=4'b0000, then Cond=0000 (EQ), RegW=1 -> after edge, RegWrite=0 and CondEx=0. Then Cond=1110, RegW=1 -> RegWrite=1.
- Compare then branch:
  - Edge 1: Cond=1110, FlagW=2'b11, ALUFlags=4'b0100, NoWrite=1, RegW=1 -> RegWrite=0, Flags=4'b0100.
  - Edge 2: Cond=0000, PCS=1 -> PCSrc=1.
- Partial write: Flags=4'b1010, Cond=1110, FlagW=2'b10, ALUFlags=4'b0101 -> Flags=4'b0110. Then with FlagW=2'b01, ALUFlags=4'b1001 -> Flags=4'b0101.
- Sweep all 16 Cond values over all 16 Flags values against the condition table. Cond=1111 always gives CondEx=0 and no flag write.
- Stall and flush:
  - `en`=0 for 3 cycles with changing inputs -> outputs and Flags hold.
  - `flush`=1 with `en`=1, Cond=1110, FlagW=2'b11, MemW=1 -> MemWrite=0, Flags unchanged.
- `COND_STATS_EN`: 5 accepted failing instructions plus 2 flushed -> `squash_count`=5. Preload at 16'hFFFF, one more failure -> stays 16'hFFFF.
